// File: rtl/crs_pkg.sv
// Shared definitions for the CRS requester: op codes, FSM states and the
// burst-buffer entry layout used by both the FIFO and the request logic.
package crs_pkg;

  localparam logic [1:0] CRS_OP_WR  = 2'd0;
  localparam logic [1:0] CRS_OP_RD  = 2'd1;
  localparam logic [1:0] CRS_OP_BWR = 2'd2;
  localparam logic [1:0] CRS_OP_RSV = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RELEASE,
    S_RSP
  } crs_state_e;

  localparam int CRS_ENT_W        = 32;
  localparam int CRS_ENT_DATA_LSB = 0;
  localparam int CRS_ENT_DATA_MSB = 15;
  localparam int CRS_ENT_ADR_LSB  = 16;
  localparam int CRS_ENT_ADR_MSB  = 27;

  // Bits [31:28] of an entry are always zero on the master side.
  function automatic logic [CRS_ENT_W-1:0] crs_pack_entry(input logic [11:0] adr,
                                                          input logic [15:0] data);
    logic [CRS_ENT_W-1:0] e;
    e = '0;
    e[CRS_ENT_ADR_MSB:CRS_ENT_ADR_LSB]   = adr;
    e[CRS_ENT_DATA_MSB:CRS_ENT_DATA_LSB] = data;
    return e;
  endfunction

endpackage

// File: rtl/crs_bw_fifo.sv
// Burst-write FIFO: the head entry is loaded into a register on each pop, so
// the master sees the popped entry from the cycle after its buf_rd strobe.
module crs_bw_fifo
  import crs_pkg::*;
#(
  parameter int BUF_AW = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_push,
  input  logic [CRS_ENT_W-1:0] i_data,
  input  logic                 i_pop,
  output logic [CRS_ENT_W-1:0] o_head,
  output logic                 o_full,
  output logic                 o_empty
);

  localparam int DEPTH = 1 << BUF_AW;
  localparam logic [BUF_AW:0] FULL_CNT = {1'b1, {BUF_AW{1'b0}}};

  logic [CRS_ENT_W-1:0] r_mem [DEPTH];
  logic [BUF_AW-1:0]    r_wr_ptr;
  logic [BUF_AW-1:0]    r_rd_ptr;
  logic [BUF_AW:0]      r_count;
  logic [CRS_ENT_W-1:0] r_head;
  logic                 w_push;
  logic                 w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_head  = r_head;
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_head   <= r_mem[r_rd_ptr];
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/crs_requester.sv
// CRS bus requester: turns host commands into wr/rd/burst-write requests,
// runs the req/ack handshake and owns the burst buffer the master drains.
module crs_requester
  import crs_pkg::*;
#(
  parameter int BUF_AW         = 6,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [11:0] cmd_adr,
  input  logic [15:0] cmd_data,
  input  logic        bw_push,
  input  logic [11:0] bw_adr,
  input  logic [15:0] bw_data,
  output logic        bw_full,
  output logic        bw_ovf,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        wr_req,
  output logic        bwr_req,
  output logic        rd_req,
  input  logic        ack,
  output logic [11:0] adr,
  output logic [15:0] wr_data,
  input  logic [15:0] rd_data,
  input  logic        buf_rd,
  output logic        buf_empty,
  output logic [31:0] buf_wr_data
);

  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  crs_state_e    r_state, w_state_nxt;
  logic [1:0]    r_op;
  logic [11:0]   r_adr;
  logic [15:0]   r_wdata;
  logic          r_wr_req, r_rd_req, r_bwr_req;
  logic [15:0]   r_cap;
  logic [15:0]   r_rsp_data;
  logic          r_rsp_err;
  logic [TW-1:0] r_tcnt;
  logic          r_ovf;
  logic          w_accept, w_ack_take, w_timeout, w_release_done;
  logic          w_full, w_bwr_busy, w_push_drop;

  assign cmd_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RSP);
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign wr_req    = r_wr_req;
  assign rd_req    = r_rd_req;
  assign bwr_req   = r_bwr_req;
  assign adr       = r_adr;
  assign wr_data   = r_wdata;
  assign bw_full   = w_full;
  assign bw_ovf    = r_ovf;

  // Pushes are refused while a drain is in flight so the master's drain is bounded.
  assign w_bwr_busy  = (r_op == CRS_OP_BWR) && ((r_state == S_REQ) || (r_state == S_RELEASE));
  assign w_push_drop = bw_push & (w_full | w_bwr_busy);

  crs_bw_fifo #(.BUF_AW(BUF_AW)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (bw_push & ~w_push_drop),
    .i_data  (crs_pack_entry(bw_adr, bw_data)),
    .i_pop   (buf_rd),
    .o_head  (buf_wr_data),
    .o_full  (w_full),
    .o_empty (buf_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_accept       = 1'b0;
    w_ack_take     = 1'b0;
    w_timeout      = 1'b0;
    w_release_done = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = (cmd_op == CRS_OP_RSV) ? S_RSP : S_REQ;
        end
      end
      S_REQ: begin
        if (ack) begin
          w_ack_take  = 1'b1;
          w_state_nxt = S_RELEASE;
        end else if ((TIMEOUT_CYCLES != 0) && (r_tcnt == TLAST)) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_RSP;
        end
      end
      S_RELEASE: begin
        if (!ack) begin
          w_release_done = 1'b1;
          w_state_nxt    = S_RSP;
        end
      end
      S_RSP:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Response fields are only rewritten on entry to S_RSP so they hold between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op       <= CRS_OP_WR;
      r_adr      <= '0;
      r_wdata    <= '0;
      r_wr_req   <= 1'b0;
      r_rd_req   <= 1'b0;
      r_bwr_req  <= 1'b0;
      r_cap      <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
      r_tcnt     <= '0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op      <= cmd_op;
        r_adr     <= cmd_adr;
        r_wdata   <= cmd_data;
        r_wr_req  <= (cmd_op == CRS_OP_WR);
        r_rd_req  <= (cmd_op == CRS_OP_RD);
        r_bwr_req <= (cmd_op == CRS_OP_BWR);
        r_tcnt    <= '0;
      end else if (r_state == S_REQ) begin
        r_tcnt <= r_tcnt + 1'b1;
      end
      if (w_ack_take || w_timeout) begin
        r_wr_req  <= 1'b0;
        r_rd_req  <= 1'b0;
        r_bwr_req <= 1'b0;
      end
      if (w_ack_take) r_cap <= (r_op == CRS_OP_RD) ? rd_data : 16'h0000;
      if (w_release_done) begin
        r_rsp_data <= r_cap;
        r_rsp_err  <= 1'b0;
      end else if (w_timeout || (w_accept && (cmd_op == CRS_OP_RSV))) begin
        r_rsp_data <= '0;
        r_rsp_err  <= 1'b1;
      end
      if (w_push_drop)                            r_ovf <= 1'b1;
      else if (w_accept && (cmd_op == CRS_OP_BWR)) r_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_crs_requester.sv
// Self-checking bench for crs_requester: acts as host and CRS master, and
// compares against a queue-based model of the burst buffer and response rules.
module tb_crs_requester;

  localparam int AW    = 6;
  localparam int DEPTH = 64;
  localparam int TMO   = 16;
  localparam logic [1:0] OP_WR  = 2'd0;
  localparam logic [1:0] OP_RD  = 2'd1;
  localparam logic [1:0] OP_BWR = 2'd2;
  localparam logic [1:0] OP_RSV = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [11:0] cmd_adr = '0;
  logic [15:0] cmd_data = '0;
  logic        bw_push = 1'b0;
  logic [11:0] bw_adr = '0;
  logic [15:0] bw_data = '0;
  logic        bw_full, bw_ovf;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        wr_req, bwr_req, rd_req;
  logic        ack = 1'b0;
  logic [11:0] adr;
  logic [15:0] wr_data;
  logic [15:0] rd_data = '0;
  logic        buf_rd = 1'b0;
  logic        buf_empty;
  logic [31:0] buf_wr_data;
  logic [2:0]  reqs;

  assign reqs = {wr_req, rd_req, bwr_req};

  crs_requester #(.BUF_AW(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_adr(cmd_adr), .cmd_data(cmd_data),
    .bw_push(bw_push), .bw_adr(bw_adr), .bw_data(bw_data),
    .bw_full(bw_full), .bw_ovf(bw_ovf),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .wr_req(wr_req), .bwr_req(bwr_req), .rd_req(rd_req), .ack(ack),
    .adr(adr), .wr_data(wr_data), .rd_data(rd_data),
    .buf_rd(buf_rd), .buf_empty(buf_empty), .buf_wr_data(buf_wr_data)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_miscmp = 0;
  logic [31:0] m_q[$];
  logic        m_ovf = 1'b0;
  logic        m_busy = 1'b0;
  logic [31:0] m_last = '0;

  typedef struct {
    logic [1:0]  op;
    logic [11:0] adr;
    logic [15:0] data;
    int          ack_dly;
    int          rel_dly;
    logic [15:0] rdv;
    logic [15:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miscmp++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] req_onehot(input logic [1:0] op);
    case (op)
      OP_WR:   return 3'b100;
      OP_RD:   return 3'b010;
      OP_BWR:  return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  // Push one entry; model: dropped when full or while a drain is in flight.
  task automatic push_entry(input logic [11:0] a, input logic [15:0] d);
    bw_push = 1'b1; bw_adr = a; bw_data = d;
    @(negedge clk);
    bw_push = 1'b0;
    if (m_busy || (m_q.size() == DEPTH)) m_ovf = 1'b1;
    else m_q.push_back({4'h0, a, d});
    chk("push_ovf", bw_ovf, m_ovf);
    chk("push_full", bw_full, m_q.size() == DEPTH);
    chk("push_empty", buf_empty, m_q.size() == 0);
  endtask

  // Master drain: one pop at a time, head sampled two cycles after buf_rd.
  task automatic drain(input bit push_during);
    while (m_q.size() > 0) begin
      buf_rd = 1'b1;
      @(negedge clk);
      buf_rd = 1'b0;
      m_last = m_q.pop_front();
      chk("pop_empty_flag", buf_empty, m_q.size() == 0);
      @(negedge clk);
      chk("pop_head", buf_wr_data, m_last);
    end
    buf_rd = 1'b1;
    @(negedge clk);
    buf_rd = 1'b0;
    @(negedge clk);
    chk("empty_pop_head", buf_wr_data, m_last);
    chk("empty_pop_flag", buf_empty, 1);
    if (push_during) push_entry(12'h7A5, 16'h5A5A);
  endtask

  // One host command with the bench acting as master; ack_dly<0 means never ack.
  task automatic applyCmd(input logic [1:0] op, input logic [11:0] a, input logic [15:0] d,
                          input int ack_dly, input int rel_dly, input logic [15:0] rdv,
                          input bit push_during, input logic [15:0] exp_data, input logic exp_err);
    int hi;
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_adr = a; cmd_data = d;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_adr = 12'($urandom); cmd_data = 16'($urandom);
    chk("cmd_ready_busy", cmd_ready, 0);
    if (op == OP_RSV) begin
      chk("rsv_no_req", reqs, 3'b000);
      chk("rsv_rsp_valid", rsp_valid, 1);
      chk("rsv_rsp_err", rsp_err, 1);
      chk("rsv_rsp_data", rsp_data, 0);
    end else begin
      chk("req_sel", reqs, req_onehot(op));
      chk("req_adr", adr, a);
      chk("req_wdata", wr_data, d);
      if (op == OP_BWR) begin
        m_ovf  = 1'b0;
        m_busy = 1'b1;
        chk("bwr_ovf_clear", bw_ovf, 0);
        if (ack_dly >= 0) drain(push_during);
      end
      if (ack_dly < 0) begin
        hi = 0;
        while ((reqs != 3'b000) && (hi < 200)) begin
          hi++;
          @(negedge clk);
        end
        chk("timeout_len", hi, TMO);
        chk("timeout_rsp_valid", rsp_valid, 1);
        chk("timeout_rsp_err", rsp_err, 1);
        chk("timeout_rsp_data", rsp_data, 0);
      end else begin
        for (int k = 0; k < ack_dly; k++) begin
          @(negedge clk);
          chk("req_hold", {reqs, adr, wr_data}, {req_onehot(op), a, d});
        end
        ack = 1'b1; rd_data = rdv;
        @(negedge clk);
        rd_data = 16'($urandom);
        chk("req_drop", reqs, 3'b000);
        for (int k = 0; k < rel_dly; k++) begin
          @(negedge clk);
          chk("release_wait", {rsp_valid, reqs}, 4'b0000);
        end
        ack = 1'b0;
        @(negedge clk);
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_data", rsp_data, exp_data);
        chk("rsp_err", rsp_err, exp_err);
      end
    end
    m_busy = 1'b0;
    @(negedge clk);
    chk("rsp_one_cycle", rsp_valid, 0);
    chk("cmd_ready_back", cmd_ready, 1);
    chk("rsp_held", {rsp_err, rsp_data}, {exp_err, exp_data});
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [1:0]  op;
    logic [15:0] ed, rdv;
    logic        ee;
    int          dly, r;

    tbl[0] = '{OP_WR,  12'h012, 16'hBEEF, 2,  0, 16'h0000, 16'h0000, 1'b0};
    tbl[1] = '{OP_RD,  12'h0FF, 16'h0000, 3,  1, 16'h1234, 16'h1234, 1'b0};
    tbl[2] = '{OP_RSV, 12'h555, 16'h1111, 0,  0, 16'h0000, 16'h0000, 1'b1};
    tbl[3] = '{OP_RD,  12'h0A5, 16'h0000, -1, 0, 16'h0000, 16'h0000, 1'b1};
    tbl[4] = '{OP_BWR, 12'h000, 16'h0000, 0,  0, 16'h0000, 16'h0000, 1'b0};
    tbl[5] = '{OP_WR,  12'hFFF, 16'hFFFF, 0,  2, 16'h0000, 16'h0000, 1'b0};
    tbl[6] = '{OP_RD,  12'h800, 16'h0001, 1,  0, 16'hFFFF, 16'hFFFF, 1'b0};

    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_buf_empty", buf_empty, 1);
    chk("rst_outputs", {reqs, rsp_valid, rsp_err, bw_full, bw_ovf}, 0);
    chk("rst_data", {adr, wr_data, rsp_data}, 0);
    chk("rst_head", buf_wr_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++)
      applyCmd(tbl[i].op, tbl[i].adr, tbl[i].data, tbl[i].ack_dly, tbl[i].rel_dly,
               tbl[i].rdv, 1'b0, tbl[i].exp_data, tbl[i].exp_err);

    push_entry(12'h001, 16'hAAAA);
    push_entry(12'h002, 16'hBBBB);
    push_entry(12'h003, 16'hCCCC);
    chk("burst_model_order", {m_q[0], m_q[1], m_q[2]}, 96'h0001AAAA_0002BBBB_0003CCCC);
    applyCmd(OP_BWR, 12'h000, 16'h0000, 1, 0, 16'h0000, 1'b1, 16'h0000, 1'b0);
    chk("drain_push_ovf", bw_ovf, 1);

    for (int i = 0; i < DEPTH; i++) push_entry(12'(i + 16), 16'($urandom));
    chk("fill_full", bw_full, 1);
    push_entry(12'hABC, 16'hDEAD);
    chk("overflow_full_kept", bw_full, 1);
    chk("overflow_ovf", bw_ovf, 1);

    cmd_valid = 1'b1; cmd_op = OP_RD; cmd_adr = 12'h123; cmd_data = 16'h0000;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rst_pre_rdreq", reqs, 3'b010);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_req", reqs, 3'b000);
    chk("async_rst_empty", buf_empty, 1);
    chk("async_rst_full", bw_full, 0);
    chk("async_rst_ovf", bw_ovf, 0);
    chk("async_rst_ready", cmd_ready, 1);
    m_q.delete(); m_ovf = 1'b0; m_last = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", cmd_ready, 1);

    for (int it = 0; it < 60; it++) begin
      r = int'($urandom_range(0, 2));
      for (int p = 0; p < r; p++)
        if (m_q.size() < 4) push_entry(12'($urandom), 16'($urandom));
      r = int'($urandom_range(0, 9));
      op  = (r < 3) ? OP_WR : (r < 6) ? OP_RD : (r < 9) ? OP_BWR : OP_RSV;
      dly = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 3));
      rdv = 16'($urandom);
      if (op == OP_RSV || dly < 0) begin ed = 16'h0000; ee = 1'b1; end
      else if (op == OP_RD)        begin ed = rdv;      ee = 1'b0; end
      else                         begin ed = 16'h0000; ee = 1'b0; end
      applyCmd(op, 12'($urandom), 16'($urandom), dly, int'($urandom_range(0, 2)), rdv,
               1'($urandom), ed, ee);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
